serial_adder_ctrl: RTL and testbench

Bit-serial adder controller that sequences a single carry flip-flop and two operand shift registers to add two WIDTH-bit operands one bit per clock, LSB first. It accepts a start pulse, runs WIDTH shift cycles under a small FSM, then publishes the result with a one-cycle done pulse. It is the sequencing block around the lab's D flip-flop storage elements and is reused wherever a low-area multi-cycle adder is needed.

---
 rtl/serial_adder_ctrl_if.sv | 32 +++
 rtl/serial_adder_ctrl.sv | 109 ++++++++++
 tb/tb_serial_adder_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_ctrl_if
// Description : Request/result bundle for the bit-serial adder controller.
//               The sub select is present only when SERIAL_ADDER_SUB_EN is
//               defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_adder_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

`ifdef SERIAL_ADDER_SUB_EN
    modport master (output start, a, b, cin, sub, input busy, done, sum, cout);
    modport slave  (input start, a, b, cin, sub, output busy, done, sum, cout);
`else
    modport master (output start, a, b, cin, input busy, done, sum, cout);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface
`default_nettype wire

// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_ctrl
// Description : Bit-serial adder. Adds two WIDTH-bit operands LSB first, one
//               bit per clock, using one carry flop and two shift registers.
//               Result is published with a one-cycle done pulse.
//               Optional macro SERIAL_ADDER_SUB_EN adds a subtract select.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    serial_adder_ctrl_if.slave bus
);
    // Counter only needs to reach WIDTH-1, so clog2(WIDTH) bits suffice.
    localparam int c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_shift  = 2'd1;
    localparam logic [1:0] c_st_finish = 2'd2;

    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_sha;
    logic [WIDTH-1:0]   r_shb;
    logic               r_carry;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;

    logic [WIDTH-1:0]   w_b_load;
    logic               w_c_load;
    logic               w_s;
    logic               w_maj;

    // Subtraction is a + ~b + 1, so only the loaded B and carry change.
`ifdef SERIAL_ADDER_SUB_EN
    assign w_b_load = bus.sub ? ~bus.b : bus.b;
    assign w_c_load = bus.sub ? 1'b1   : bus.cin;
`else
    assign w_b_load = bus.b;
    assign w_c_load = bus.cin;
`endif

    // Full-adder slice on the current LSBs.
    assign w_s   = r_sha[0] ^ r_shb[0] ^ r_carry;
    assign w_maj = (r_sha[0] & r_shb[0]) | (r_sha[0] & r_carry) | (r_shb[0] & r_carry);

    // Sequencer: load in IDLE, WIDTH shift edges, publish in FINISH.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_sha   <= '0;
            r_shb   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (bus.start) begin
                        r_sha   <= bus.a;
                        r_shb   <= w_b_load;
                        r_carry <= w_c_load;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= c_st_shift;
                    end
                end
                c_st_shift: begin
                    // Result bits enter at the MSB and migrate down into place.
                    r_sha   <= {w_s, r_sha[WIDTH-1:1]};
                    r_shb   <= {1'b0, r_shb[WIDTH-1:1]};
                    r_carry <= w_maj;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == c_last) begin
                        r_state <= c_st_finish;
                    end
                end
                c_st_finish: begin
                    r_sum   <= r_sha;
                    r_cout  <= r_carry;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= c_st_idle;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_adder_ctrl
// Description : Directed, table-driven bench for serial_adder_ctrl (WIDTH=8).
//               Define SERIAL_ADDER_SUB_EN to include subtract vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder_ctrl;
    localparam int WIDTH = 8;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] sum;
        logic       cout;
    } vec_t;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    vec_t vecs[$];

    serial_adder_ctrl_if #(.WIDTH(WIDTH)) bus ();

    serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where done is seen.
    task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input logic icin,
                          input logic isub, output int busy_cyc, output bit seen);
        bus.start = 1'b1;
        bus.a     = ia;
        bus.b     = ib;
        bus.cin   = icin;
`ifdef SERIAL_ADDER_SUB_EN
        bus.sub   = isub;
`else
        if (isub) $display("note: sub vector skipped in add-only build");
`endif
        @(negedge clk);
        bus.start = 1'b0;
        busy_cyc  = 0;
        seen      = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
            if (bus.busy) busy_cyc++;
            @(negedge clk);
        end
    endtask

    initial begin
        int  bc;
        bit  seen;
        int  dones;
        int  d_at[$];
        int  busy_low;
        logic [7:0] cap_sum;
        logic       cap_cout;

        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        bus.sub   = 1'b0;
`endif

        vecs.push_back('{8'h35, 8'h4A, 1'b0, 1'b0, 8'h7F, 1'b0});
        vecs.push_back('{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1});
        vecs.push_back('{8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1});
        vecs.push_back('{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1});
        vecs.push_back('{8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0});
        vecs.push_back('{8'hAA, 8'h55, 1'b0, 1'b0, 8'hFF, 1'b0});
        vecs.push_back('{8'hAA, 8'h55, 1'b1, 1'b0, 8'h00, 1'b1});
        vecs.push_back('{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0});
`ifdef SERIAL_ADDER_SUB_EN
        vecs.push_back('{8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1});
        vecs.push_back('{8'h10, 8'h01, 1'b1, 1'b1, 8'h0F, 1'b1});
        vecs.push_back('{8'h01, 8'h02, 1'b0, 1'b1, 8'hFF, 1'b0});
        vecs.push_back('{8'h01, 8'h02, 1'b1, 1'b1, 8'hFF, 1'b0});
        vecs.push_back('{8'h05, 8'h05, 1'b0, 1'b1, 8'h00, 1'b1});
`endif

        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_busy", {31'd0, bus.busy}, 32'd0);
        chk("reset_done", {31'd0, bus.done}, 32'd0);
        chk("reset_sum",  {24'd0, bus.sum},  32'd0);
        chk("reset_cout", {31'd0, bus.cout}, 32'd0);

        // Vector table
        foreach (vecs[k]) begin
            run_op(vecs[k].a, vecs[k].b, vecs[k].cin, vecs[k].sub, bc, seen);
            chk($sformatf("v%0d_done_seen", k), {31'd0, seen}, 32'd1);
            chk($sformatf("v%0d_sum", k),  {24'd0, bus.sum},  {24'd0, vecs[k].sum});
            chk($sformatf("v%0d_cout", k), {31'd0, bus.cout}, {31'd0, vecs[k].cout});
            chk($sformatf("v%0d_busy_cycles", k), bc, WIDTH + 1);
            chk($sformatf("v%0d_busy_in_done", k), {31'd0, bus.busy}, 32'd0);
            @(negedge clk);
            chk($sformatf("v%0d_done_pulse", k), {31'd0, bus.done}, 32'd0);
        end

        // Start and operand changes while busy are ignored
        bus.start = 1'b1; bus.a = 8'h12; bus.b = 8'h34; bus.cin = 1'b0;
        @(negedge clk);               // E0 passed
        bus.start = 1'b0;
        @(negedge clk);               // E1
        @(negedge clk);               // E2
        bus.start = 1'b1; bus.a = 8'hFF; bus.b = 8'hFF; bus.cin = 1'b1;
        @(negedge clk);               // E3 passed
        bus.start = 1'b0;
        dones = 0; cap_sum = '0; cap_cout = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (bus.done) begin
                dones++;
                cap_sum  = bus.sum;
                cap_cout = bus.cout;
            end
            @(negedge clk);
        end
        chk("ign_done_count", dones, 1);
        chk("ign_sum",  {24'd0, cap_sum},  32'h46);
        chk("ign_cout", {31'd0, cap_cout}, 32'd0);

        // Back-to-back with start held: accept-to-accept is IDLE+8 SHIFT+FINISH
        bus.start = 1'b1; bus.a = 8'h01; bus.b = 8'h01; bus.cin = 1'b0;
        busy_low = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (bus.done) begin
                d_at.push_back(i);
                chk($sformatf("b2b_sum_%0d", d_at.size()), {24'd0, bus.sum}, 32'h02);
            end
            if (d_at.size() == 1 && !bus.busy) busy_low++;
        end
        bus.start = 1'b0;
        chk("b2b_done_count_ge3", {31'd0, d_at.size() >= 3}, 32'd1);
        if (d_at.size() >= 3) begin
            chk("b2b_first_done", d_at[0], WIDTH + 2);
            chk("b2b_interval1", d_at[1] - d_at[0], WIDTH + 2);
            chk("b2b_interval2", d_at[2] - d_at[1], WIDTH + 2);
        end
        chk("b2b_busy_low_cycles", busy_low, 1);
        repeat (WIDTH + 4) @(negedge clk);

        // Reset at E4 of an operation, with start also high on that edge
        bus.start = 1'b1; bus.a = 8'h35; bus.b = 8'h4A; bus.cin = 1'b0;
        @(negedge clk);               // E0 passed
        bus.start = 1'b0;
        repeat (3) @(negedge clk);    // E1..E3
        rst = 1'b1; bus.start = 1'b1;
        @(negedge clk);               // E4 with rst
        rst = 1'b0; bus.start = 1'b0;
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_sum",  {24'd0, bus.sum},  32'd0);
        chk("rst_cout", {31'd0, bus.cout}, 32'd0);
        dones = 0;
        bc    = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.done) dones++;
            if (bus.busy) bc++;
        end
        chk("rst_no_done", dones, 0);
        chk("rst_no_accept", bc, 0);
        run_op(8'h35, 8'h4A, 1'b0, 1'b0, bc, seen);
        chk("post_rst_done_seen", {31'd0, seen}, 32'd1);
        chk("post_rst_sum",  {24'd0, bus.sum},  32'h7F);
        chk("post_rst_cout", {31'd0, bus.cout}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
